// File: rtl/mem_port_arbiter.sv
// Two-port ownership arbiter for the shared memory command/read/write port.
// Port 0 (VGA fetch) and port 1 (CPU LSU) request/grant/done with round-robin and urgent override.
module mem_port_arbiter #(
  parameter int unsigned MAX_HOLD = 1024,
  parameter int unsigned CNT_W    = 11
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p0_req,
  input  logic        p0_urgent,
  output logic        p0_gnt,
  input  logic        p0_done,
  input  logic        p0_cmd_en,
  input  logic [2:0]  p0_cmd_instr,
  input  logic [5:0]  p0_cmd_bl,
  input  logic [29:0] p0_cmd_byte_addr,
  output logic        p0_cmd_full,
  input  logic        p0_wr_en,
  input  logic [31:0] p0_wr_data,
  input  logic [3:0]  p0_wr_mask,
  input  logic        p0_rd_en,
  output logic        p0_rd_empty,
  output logic [31:0] p0_rd_data,

  input  logic        p1_req,
  output logic        p1_gnt,
  input  logic        p1_done,
  input  logic        p1_cmd_en,
  input  logic [2:0]  p1_cmd_instr,
  input  logic [5:0]  p1_cmd_bl,
  input  logic [29:0] p1_cmd_byte_addr,
  output logic        p1_cmd_full,
  input  logic        p1_wr_en,
  input  logic [31:0] p1_wr_data,
  input  logic [3:0]  p1_wr_mask,
  input  logic        p1_rd_en,
  output logic        p1_rd_empty,
  output logic [31:0] p1_rd_data,

  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  output logic        mem_wr_en,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_wr_mask,
  output logic        mem_rd_en,
  input  logic        mem_cmd_empty,
  input  logic        mem_cmd_full,
  input  logic        mem_rd_empty,
  input  logic [31:0] mem_rd_data,

  output logic        hold_timeout
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, DRAIN} state_t;

  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             own0, own1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (p0_req && p0_urgent)      state_d = GNT0;
        else if (p0_req && p1_req)    state_d = last_q ? GNT0 : GNT1;
        else if (p0_req)              state_d = GNT0;
        else if (p1_req)              state_d = GNT1;
      end
      GNT0: begin
        if (p0_done) begin
          state_d = DRAIN;
          last_d  = 1'b0;
        end
      end
      GNT1: begin
        if (p1_done) begin
          state_d = DRAIN;
          last_d  = 1'b1;
        end
      end
      DRAIN: begin
        if (mem_cmd_empty && mem_rd_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter is zeroed while idle so the first grant cycle always sees 0.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (state_q == IDLE)
      hold_cnt_d = '0;
    else if ((own0 || own1) && hold_cnt_q != HOLD_MAX)
      hold_cnt_d = hold_cnt_q + 1'b1;
  end

  assign own0   = (state_q == GNT0);
  assign own1   = (state_q == GNT1);
  assign p0_gnt = own0;
  assign p1_gnt = own1;

  // Enables are masked by rst so nothing reaches memory while reset is held.
  always_comb begin
    mem_cmd_en        = !rst && ((own0 && p0_cmd_en) || (own1 && p1_cmd_en));
    mem_wr_en         = !rst && ((own0 && p0_wr_en)  || (own1 && p1_wr_en));
    mem_rd_en         = !rst && ((own0 && p0_rd_en)  || (own1 && p1_rd_en));
    mem_cmd_instr     = own1 ? p1_cmd_instr     : p0_cmd_instr;
    mem_cmd_bl        = own1 ? p1_cmd_bl        : p0_cmd_bl;
    mem_cmd_byte_addr = own1 ? p1_cmd_byte_addr : p0_cmd_byte_addr;
    mem_wr_data       = own1 ? p1_wr_data       : p0_wr_data;
    mem_wr_mask       = own1 ? p1_wr_mask       : p0_wr_mask;
  end

  assign p0_cmd_full = mem_cmd_full | ~own0;
  assign p1_cmd_full = mem_cmd_full | ~own1;
  assign p0_rd_empty = mem_rd_empty | ~own0;
  assign p1_rd_empty = mem_rd_empty | ~own1;
  assign p0_rd_data  = mem_rd_data;
  assign p1_rd_data  = mem_rd_data;

  assign hold_timeout = !rst && (hold_cnt_q == HOLD_LAST) &&
                        ((own0 && p1_req) || (own1 && p0_req));

  a_one_gnt: assert property (@(posedge clk) !(p0_gnt && p1_gnt));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: mux table in GNT1 plus multi-cycle ownership sequences.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_urgent, p0_gnt, p0_done, p0_cmd_en, p0_cmd_full;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic        p0_wr_en, p0_rd_en, p0_rd_empty;
  logic [31:0] p0_wr_data, p0_rd_data;
  logic [3:0]  p0_wr_mask;
  logic        p1_req, p1_gnt, p1_done, p1_cmd_en, p1_cmd_full;
  logic [2:0]  p1_cmd_instr;
  logic [5:0]  p1_cmd_bl;
  logic [29:0] p1_cmd_byte_addr;
  logic        p1_wr_en, p1_rd_en, p1_rd_empty;
  logic [31:0] p1_wr_data, p1_rd_data;
  logic [3:0]  p1_wr_mask;
  logic        mem_cmd_en, mem_wr_en, mem_rd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic [31:0] mem_wr_data, mem_rd_data;
  logic [3:0]  mem_wr_mask;
  logic        mem_cmd_empty, mem_cmd_full, mem_rd_empty;
  logic        hold_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_urgent(p0_urgent), .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .p0_cmd_full(p0_cmd_full),
    .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data), .p0_wr_mask(p0_wr_mask),
    .p0_rd_en(p0_rd_en), .p0_rd_empty(p0_rd_empty), .p0_rd_data(p0_rd_data),
    .p1_req(p1_req), .p1_gnt(p1_gnt), .p1_done(p1_done),
    .p1_cmd_en(p1_cmd_en), .p1_cmd_instr(p1_cmd_instr), .p1_cmd_bl(p1_cmd_bl),
    .p1_cmd_byte_addr(p1_cmd_byte_addr), .p1_cmd_full(p1_cmd_full),
    .p1_wr_en(p1_wr_en), .p1_wr_data(p1_wr_data), .p1_wr_mask(p1_wr_mask),
    .p1_rd_en(p1_rd_en), .p1_rd_empty(p1_rd_empty), .p1_rd_data(p1_rd_data),
    .mem_cmd_en(mem_cmd_en), .mem_cmd_instr(mem_cmd_instr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_byte_addr(mem_cmd_byte_addr), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask), .mem_rd_en(mem_rd_en),
    .mem_cmd_empty(mem_cmd_empty), .mem_cmd_full(mem_cmd_full),
    .mem_rd_empty(mem_rd_empty), .mem_rd_data(mem_rd_data),
    .hold_timeout(hold_timeout)
  );

  typedef struct {
    logic        p0_cmd_en, p1_cmd_en, p0_wr_en, p1_wr_en, p0_rd_en, p1_rd_en;
    logic [2:0]  p1_instr;
    logic [5:0]  p1_bl;
    logic [29:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_mask;
    logic        mcf, mre;
    logic [31:0] mrdata;
    logic        e_cmd_en, e_wr_en, e_rd_en, e_p0_full, e_p1_full, e_p0_empty, e_p1_empty;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnt(input string name, input logic e0, input logic e1);
    check({name, ".gnt0"}, {31'd0, p0_gnt}, {31'd0, e0});
    check({name, ".gnt1"}, {31'd0, p1_gnt}, {31'd0, e1});
  endtask

  task automatic clear_inputs();
    p0_req = 0; p0_urgent = 0; p0_done = 0; p0_cmd_en = 0; p0_wr_en = 0; p0_rd_en = 0;
    p1_req = 0; p1_done = 0; p1_cmd_en = 0; p1_wr_en = 0; p1_rd_en = 0;
    p0_cmd_instr = 3'd7; p0_cmd_bl = 6'h3f; p0_cmd_byte_addr = 30'h3fff_0000;
    p0_wr_data = 32'hdead_beef; p0_wr_mask = 4'hf;
    p1_cmd_instr = 3'd0; p1_cmd_bl = 6'd0; p1_cmd_byte_addr = 30'd0;
    p1_wr_data = 32'd0; p1_wr_mask = 4'h0;
    mem_cmd_empty = 1; mem_cmd_full = 0; mem_rd_empty = 1; mem_rd_data = 32'h1234_5678;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    repeat (2) tick();
    rst = 0;
  endtask

  int pulses;

  initial begin
    // {en flags(p0c,p1c,p0w,p1w,p0r,p1r), p1 fields, mcf, mre, rdata, expected}
    vecs[0] = '{1,0,0,0,0,0, 3'd1, 6'd3,  30'h0000_1000, 32'h1111_1111, 4'h1, 0,0, 32'haaaa_0001, 0,0,0, 1,0, 1,0};
    vecs[1] = '{1,1,0,0,0,0, 3'd0, 6'd15, 30'h0abc_0004, 32'h2222_2222, 4'h3, 0,0, 32'haaaa_0002, 1,0,0, 1,0, 1,0};
    vecs[2] = '{0,1,0,0,0,0, 3'd2, 6'd0,  30'h1234_5678, 32'h3333_3333, 4'h7, 1,0, 32'haaaa_0003, 1,0,0, 1,1, 1,0};
    vecs[3] = '{0,0,1,0,0,0, 3'd3, 6'd31, 30'h2000_0000, 32'h4444_4444, 4'h8, 0,1, 32'haaaa_0004, 0,0,0, 1,0, 1,1};
    vecs[4] = '{0,0,0,1,0,1, 3'd4, 6'd63, 30'h0000_0010, 32'h5555_5555, 4'hc, 0,0, 32'haaaa_0005, 0,1,1, 1,0, 1,0};
    vecs[5] = '{0,0,0,0,1,0, 3'd5, 6'd7,  30'h0000_0020, 32'h6666_6666, 4'h0, 1,1, 32'haaaa_0006, 0,0,0, 1,1, 1,1};

    // Reset state, with port 0 pushing commands while reset is held
    clear_inputs();
    rst = 1;
    p0_req = 1; p0_cmd_en = 1;
    repeat (3) tick();
    check_gnt("reset", 0, 0);
    check("reset.mem_cmd_en", {31'd0, mem_cmd_en}, 32'd0);
    check("reset.hold_timeout", {31'd0, hold_timeout}, 32'd0);
    do_reset();

    // Single p1 request pulse, done on the 5th grant cycle
    p1_req = 1;
    #1 check_gnt("p1pulse.pre", 0, 0);
    tick();
    p1_req = 0;
    for (int k = 1; k <= 5; k++) begin
      check_gnt($sformatf("p1pulse.g%0d", k), 0, 1);
      if (k == 5) p1_done = 1;
      tick();
    end
    p1_done = 0;
    check_gnt("p1pulse.drain", 0, 0);
    tick();
    check_gnt("p1pulse.idle", 0, 0);

    // Round robin with both requests held; done on first grant cycle
    do_reset();
    p0_req = 1; p1_req = 1;
    for (int g = 0; g < 4; g++) begin
      tick();
      check_gnt($sformatf("rr.g%0d", g), (g % 2) == 0, (g % 2) == 1);
      if ((g % 2) == 0) begin
        p0_cmd_en = 1;
        #1;
        check("rr.own0.mem_cmd_en", {31'd0, mem_cmd_en}, 32'd1);
        check("rr.own0.p0_cmd_full", {31'd0, p0_cmd_full}, 32'd0);
        p0_cmd_en = 0;
        p0_done = 1;
      end else begin
        p1_done = 1;
      end
      tick();
      p0_done = 0; p1_done = 0;
      check_gnt($sformatf("rr.drain%0d", g), 0, 0);
      tick();
      check_gnt($sformatf("rr.idle%0d", g), 0, 0);
    end

    // Urgent p0 does not preempt p1; p0 wins after p1 releases even though p1 re-requests
    do_reset();
    p1_req = 1;
    tick();
    p0_req = 1; p0_urgent = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_gnt("urg.keep", 0, 1);
    end
    p1_done = 1;
    tick();
    p1_done = 0;
    check_gnt("urg.drain", 0, 0);
    tick();
    tick();
    check_gnt("urg.next", 1, 0);
    // last=0 now: urgent beats round robin
    p0_done = 1;
    tick();
    p0_done = 0;
    tick();
    tick();
    check_gnt("urg.override", 1, 0);
    // same tie without urgent goes to port 1
    p0_urgent = 0; p0_done = 1;
    tick();
    p0_done = 0;
    tick();
    tick();
    check_gnt("urg.rr_back", 0, 1);

    // Mux table while port 1 owns; port 1 drops req but keeps ownership
    do_reset();
    p1_req = 1;
    tick();
    p1_req = 0;
    foreach (vecs[i]) begin
      p0_cmd_en = vecs[i].p0_cmd_en; p1_cmd_en = vecs[i].p1_cmd_en;
      p0_wr_en  = vecs[i].p0_wr_en;  p1_wr_en  = vecs[i].p1_wr_en;
      p0_rd_en  = vecs[i].p0_rd_en;  p1_rd_en  = vecs[i].p1_rd_en;
      p1_cmd_instr = vecs[i].p1_instr; p1_cmd_bl = vecs[i].p1_bl;
      p1_cmd_byte_addr = vecs[i].p1_addr; p1_wr_data = vecs[i].p1_wdata;
      p1_wr_mask = vecs[i].p1_mask;
      mem_cmd_full = vecs[i].mcf; mem_rd_empty = vecs[i].mre; mem_rd_data = vecs[i].mrdata;
      #1;
      check($sformatf("v%0d.cmd_en", i), {31'd0, mem_cmd_en}, {31'd0, vecs[i].e_cmd_en});
      check($sformatf("v%0d.instr", i), {29'd0, mem_cmd_instr}, {29'd0, vecs[i].p1_instr});
      check($sformatf("v%0d.bl", i), {26'd0, mem_cmd_bl}, {26'd0, vecs[i].p1_bl});
      check($sformatf("v%0d.addr", i), {2'd0, mem_cmd_byte_addr}, {2'd0, vecs[i].p1_addr});
      check($sformatf("v%0d.wr_en", i), {31'd0, mem_wr_en}, {31'd0, vecs[i].e_wr_en});
      check($sformatf("v%0d.wdata", i), mem_wr_data, vecs[i].p1_wdata);
      check($sformatf("v%0d.mask", i), {28'd0, mem_wr_mask}, {28'd0, vecs[i].p1_mask});
      check($sformatf("v%0d.rd_en", i), {31'd0, mem_rd_en}, {31'd0, vecs[i].e_rd_en});
      check($sformatf("v%0d.p0_full", i), {31'd0, p0_cmd_full}, {31'd0, vecs[i].e_p0_full});
      check($sformatf("v%0d.p1_full", i), {31'd0, p1_cmd_full}, {31'd0, vecs[i].e_p1_full});
      check($sformatf("v%0d.p0_empty", i), {31'd0, p0_rd_empty}, {31'd0, vecs[i].e_p0_empty});
      check($sformatf("v%0d.p1_empty", i), {31'd0, p1_rd_empty}, {31'd0, vecs[i].e_p1_empty});
      check($sformatf("v%0d.p0_rdata", i), p0_rd_data, vecs[i].mrdata);
      check($sformatf("v%0d.p1_rdata", i), p1_rd_data, vecs[i].mrdata);
    end
    clear_inputs();
    tick();
    check_gnt("tbl.kept", 0, 1);

    // Reset mid-burst
    p1_cmd_en = 1; p1_wr_en = 1; p1_rd_en = 1;
    rst = 1;
    #1;
    check("rstmid.cmd_en", {31'd0, mem_cmd_en}, 32'd0);
    check("rstmid.wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rstmid.rd_en", {31'd0, mem_rd_en}, 32'd0);
    tick();
    check_gnt("rstmid.after", 0, 0);
    rst = 0;
    clear_inputs();

    // Drain stalls while read data is left unread
    p0_req = 1;
    tick();
    check_gnt("drain.own", 1, 0);
    p0_cmd_en = 1; p0_cmd_instr = 3'd1; p0_cmd_bl = 6'd3; p0_cmd_byte_addr = 30'h100;
    #1;
    check("drain.cmd_en", {31'd0, mem_cmd_en}, 32'd1);
    check("drain.cmd_bl", {26'd0, mem_cmd_bl}, 32'd3);
    tick();
    p0_cmd_en = 0; mem_rd_empty = 0;
    p0_done = 1; p0_req = 0; p1_req = 1;
    tick();
    p0_done = 0; p0_rd_en = 1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_gnt($sformatf("drain.stall%0d", k), 0, 0);
      check("drain.rd_en", {31'd0, mem_rd_en}, 32'd0);
      check("drain.p0_empty", {31'd0, p0_rd_empty}, 32'd1);
      tick();
    end
    mem_rd_empty = 1; mem_cmd_empty = 0;
    tick();
    check_gnt("drain.cmdwait", 0, 0);
    mem_cmd_empty = 1;
    tick();
    check_gnt("drain.idle", 0, 0);
    tick();
    check_gnt("drain.regrant", 0, 1);

    // Hold timeout with MAX_HOLD=8
    do_reset();
    p1_req = 1;
    tick();
    p0_req = 1;
    pulses = 0;
    #1;
    for (int k = 1; k <= 20; k++) begin
      if (hold_timeout === 1'b1) pulses++;
      check($sformatf("hold.c%0d", k), {31'd0, hold_timeout}, {31'd0, k == 8});
      tick();
    end
    check("hold.pulses", pulses, 32'd1);
    check_gnt("hold.noforce", 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
